// File: rtl/read_iq_block_pkg.sv
// Shared constants, FSM state encoding and sample quantizer for the read_iq front-end.
package read_iq_pkg;

   localparam int DATA_SIZE  = 32;
   localparam int BYTE_SIZE  = 8;
   localparam int CHAR_SIZE  = 16;
   localparam int BITS       = 10;
   localparam int FIFO_DEPTH = 16;

   typedef enum logic [2:0] {
      S_I_LO,
      S_I_HI,
      S_Q_LO,
      S_Q_HI,
      S_WRITE
   } state_t;

   // Upper BITS bits of the sign-extended value fall off the top of the word.
   function automatic logic [DATA_SIZE-1:0] quantize(input logic [CHAR_SIZE-1:0] raw);
      logic [DATA_SIZE-1:0] ext;
      ext = {{(DATA_SIZE-CHAR_SIZE){raw[CHAR_SIZE-1]}}, raw};
      return ext << BITS;
   endfunction

endpackage

// File: rtl/read_iq_block_if.sv
// Byte-stream input and I/Q FWFT output handshake bundle of read_iq_block.
interface read_iq_block_if;
   import read_iq_pkg::*;

   logic                 in_full;
   logic                 in_wr_en;
   logic [BYTE_SIZE-1:0] in_din;
   logic                 i_out_empty;
   logic                 q_out_empty;
   logic                 i_out_rd_en;
   logic                 q_out_rd_en;
   logic [DATA_SIZE-1:0] i_out_data;
   logic [DATA_SIZE-1:0] q_out_data;

   modport master (
      input  in_full, i_out_empty, q_out_empty, i_out_data, q_out_data,
      output in_wr_en, in_din, i_out_rd_en, q_out_rd_en
   );

   modport slave (
      output in_full, i_out_empty, q_out_empty, i_out_data, q_out_data,
      input  in_wr_en, in_din, i_out_rd_en, q_out_rd_en
   );

endinterface

// File: rtl/read_iq_block_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_do_wr = i_wr_en && !o_full;
   assign w_do_rd = i_rd_en && !o_empty;

   // Head reads as zero while empty so nothing stale is ever presented.
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/read_iq_block.sv
// FM radio front-end: assembles little-endian I/Q byte pairs from the raw stream,
// quantizes them and pushes each pair into twin FWFT output FIFOs.
//
// state   | meaning
// S_I_LO  | waiting for / taking I low byte
// S_I_HI  | waiting for / taking I high byte
// S_Q_LO  | waiting for / taking Q low byte
// S_Q_HI  | waiting for / taking Q high byte
// S_WRITE | pair assembled; push to both outputs once both have room
module read_iq_block
   import read_iq_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   read_iq_block_if.slave  bus
);

   state_t               r_state;
   state_t               w_next_state;
   logic [BYTE_SIZE-1:0] r_i_lo;
   logic [BYTE_SIZE-1:0] r_i_hi;
   logic [BYTE_SIZE-1:0] r_q_lo;
   logic [BYTE_SIZE-1:0] r_q_hi;

   logic                 w_in_empty;
   logic                 w_in_rd_en;
   logic [BYTE_SIZE-1:0] w_in_dout;
   logic                 w_i_full;
   logic                 w_q_full;
   logic                 w_out_wr_en;
   logic [DATA_SIZE-1:0] w_i_quant;
   logic [DATA_SIZE-1:0] w_q_quant;

   sync_fifo #(.WIDTH(BYTE_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_wr_en (bus.in_wr_en),
      .i_din   (bus.in_din),
      .o_full  (bus.in_full),
      .i_rd_en (w_in_rd_en),
      .o_dout  (w_in_dout),
      .o_empty (w_in_empty)
   );

   sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_i_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_wr_en (w_out_wr_en),
      .i_din   (w_i_quant),
      .o_full  (w_i_full),
      .i_rd_en (bus.i_out_rd_en),
      .o_dout  (bus.i_out_data),
      .o_empty (bus.i_out_empty)
   );

   sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_q_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_wr_en (w_out_wr_en),
      .i_din   (w_q_quant),
      .o_full  (w_q_full),
      .i_rd_en (bus.q_out_rd_en),
      .o_dout  (bus.q_out_data),
      .o_empty (bus.q_out_empty)
   );

   assign w_i_quant = quantize({r_i_hi, r_i_lo});
   assign w_q_quant = quantize({r_q_hi, r_q_lo});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_I_LO;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_rd_en   = 1'b0;
      w_out_wr_en  = 1'b0;
      case (r_state)
         S_I_LO: begin
            w_in_rd_en = !w_in_empty;
            if (!w_in_empty) w_next_state = S_I_HI;
         end
         S_I_HI: begin
            w_in_rd_en = !w_in_empty;
            if (!w_in_empty) w_next_state = S_Q_LO;
         end
         S_Q_LO: begin
            w_in_rd_en = !w_in_empty;
            if (!w_in_empty) w_next_state = S_Q_HI;
         end
         S_Q_HI: begin
            w_in_rd_en = !w_in_empty;
            if (!w_in_empty) w_next_state = S_WRITE;
         end
         S_WRITE: begin
            // I and Q always land together so the two outputs never drift apart.
            if (!w_i_full && !w_q_full) begin
               w_out_wr_en  = 1'b1;
               w_next_state = S_I_LO;
            end
         end
         default: w_next_state = S_I_LO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_i_lo <= '0;
         r_i_hi <= '0;
         r_q_lo <= '0;
         r_q_hi <= '0;
      end else if (w_in_rd_en) begin
         case (r_state)
            S_I_LO:  r_i_lo <= w_in_dout;
            S_I_HI:  r_i_hi <= w_in_dout;
            S_Q_LO:  r_q_lo <= w_in_dout;
            S_Q_HI:  r_q_hi <= w_in_dout;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_read_iq_block.sv
// Scoreboard bench for read_iq_block: accepted bytes feed a reference model,
// an independent monitor pops expected I/Q pairs on every output read.
module tb_read_iq_block;
   import read_iq_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;

   read_iq_block_if bus ();

   read_iq_block dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   int          pops  = 0;
   logic [31:0] exp_i [$];
   logic [31:0] exp_q [$];
   logic [7:0]  part  [$];
   bit          drain_en = 1'b0;
   bit          rd_dense = 1'b1;

   function automatic logic [31:0] ref_quant(input logic [7:0] lo, input logic [7:0] hi);
      int v;
      v = int'(hi) * 256 + int'(lo);
      if (v >= 32768) v = v - 65536;
      return 32'(v * 1024);
   endfunction

   function automatic void accept(input logic [7:0] b);
      part.push_back(b);
      if (part.size() == 4) begin
         exp_i.push_back(ref_quant(part[0], part[1]));
         exp_q.push_back(ref_quant(part[2], part[3]));
         part.delete();
      end
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: a read strobe seen before the edge means the head is popped on that edge.
   always @(negedge clock) begin
      if (reset) begin
         check("empty_lockstep", 32'(bus.i_out_empty), 32'(bus.q_out_empty));
         if (bus.i_out_rd_en) begin
            if (exp_i.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pair: got I=%h Q=%h, expected no output", bus.i_out_data, bus.q_out_data);
            end else begin
               check("i_data", bus.i_out_data, exp_i.pop_front());
               check("q_data", bus.q_out_data, exp_q.pop_front());
               pops++;
            end
         end
      end
   end

   initial begin : reader
      logic rd;
      bus.i_out_rd_en = 1'b0;
      bus.q_out_rd_en = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         rd = drain_en && reset && !bus.i_out_empty && !bus.q_out_empty &&
              (rd_dense || ($urandom_range(0, 2) != 0));
         bus.i_out_rd_en = rd;
         bus.q_out_rd_en = rd;
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      int n = 0;
      while (bus.in_full && n < 1000) begin
         tick();
         n++;
      end
      if (bus.in_full) begin
         tests++;
         fails++;
         $display("FAIL write_timeout: in_full stuck at 1, expected 0");
      end else begin
         bus.in_wr_en = 1'b1;
         bus.in_din   = b;
         tick();
         accept(b);
         bus.in_wr_en = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_i.size() != 0 && n < 5000) begin
         tick();
         n++;
      end
      check("drain_done", 32'(exp_i.size()), 32'd0);
   endtask

   task automatic expect_pair(input string name, input logic [31:0] ei, input logic [31:0] eq);
      int n = 0;
      while (bus.i_out_empty && n < 100) begin
         tick();
         n++;
      end
      check({name, "_i"}, bus.i_out_data, ei);
      check({name, "_q"}, bus.q_out_data, eq);
      drain_en = 1'b1;
      wait_drain();
      drain_en = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_in_full"}, 32'(bus.in_full), 32'd0);
      check({name, "_i_empty"}, 32'(bus.i_out_empty), 32'd1);
      check({name, "_q_empty"}, 32'(bus.q_out_empty), 32'd1);
      check({name, "_i_data"}, bus.i_out_data, 32'd0);
      check({name, "_q_data"}, bus.q_out_data, 32'd0);
   endtask

   initial begin : main
      int idx;
      int stall;
      int pops0;
      logic [7:0] b;
      bus.in_wr_en = 1'b0;
      bus.in_din   = '0;

      repeat (3) @(posedge clock);
      #1;
      check_idle("in_reset");
      @(negedge clock);
      reset = 1'b1;
      tick();
      check_idle("after_reset");

      write_byte(8'h34); write_byte(8'h12); write_byte(8'h78); write_byte(8'h56);
      expect_pair("basic", 32'h0048D000, 32'h0159E000);

      write_byte(8'h00); write_byte(8'h80); write_byte(8'hFF); write_byte(8'hFF);
      expect_pair("sign", 32'hFE000000, 32'hFFFFFC00);

      // Partial sample stays invisible; the 4th byte completes exactly one pair.
      write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC);
      repeat (10) tick();
      check("partial_i_empty", 32'(bus.i_out_empty), 32'd1);
      check("partial_q_empty", 32'(bus.q_out_empty), 32'd1);
      write_byte(8'hDD);
      check("latency_n_i_empty", 32'(bus.i_out_empty), 32'd1);
      tick();
      check("latency_n1_i_empty", 32'(bus.i_out_empty), 32'd1);
      pops0 = pops;
      drain_en = 1'b1;
      idx = 0;
      while (exp_i.size() != 0 && idx < 100) begin
         tick();
         idx++;
      end
      repeat (10) tick();
      drain_en = 1'b0;
      check("partial_pairs", 32'(pops - pops0), 32'd1);
      check("partial_i_empty_after", 32'(bus.i_out_empty), 32'd1);

      // Backpressure: 16 out pairs + 1 held in S_WRITE + 16 input bytes = 84 bytes.
      pops0 = pops;
      idx = 0;
      stall = 0;
      while (idx < 200 && stall < 40) begin
         if (!bus.in_full) begin
            b = 8'($urandom);
            bus.in_wr_en = 1'b1;
            bus.in_din   = b;
            tick();
            accept(b);
            bus.in_wr_en = 1'b0;
            idx++;
            stall = 0;
         end else begin
            tick();
            stall++;
         end
      end
      check("bp_accepted", 32'(idx), 32'd84);
      check("bp_in_full", 32'(bus.in_full), 32'd1);
      check("bp_i_not_empty", 32'(bus.i_out_empty), 32'd0);
      check("bp_q_not_empty", 32'(bus.q_out_empty), 32'd0);
      drain_en = 1'b1;
      while (idx < 200) begin
         write_byte(8'($urandom));
         idx++;
      end
      wait_drain();
      drain_en = 1'b0;
      check("bp_pairs", 32'(pops - pops0), 32'd50);

      // Reset mid-sample discards the two buffered bytes.
      write_byte(8'h11); write_byte(8'h22);
      #2;
      reset = 1'b0;
      #1;
      check_idle("mid_reset");
      part.delete();
      exp_i.delete();
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      tick();
      check_idle("post_mid_reset");
      write_byte(8'h01); write_byte(8'h00); write_byte(8'h02); write_byte(8'h00);
      expect_pair("realign", 32'h00000400, 32'h00000800);

      // Random reads with gaps.
      pops0 = pops;
      rd_dense = 1'b0;
      drain_en = 1'b1;
      for (int k = 0; k < 400; k++) write_byte(8'($urandom));
      wait_drain();
      rd_dense = 1'b1;
      check("gap_pairs", 32'(pops - pops0), 32'd100);

      // Sustained stream with lockstep reads.
      pops0 = pops;
      for (int k = 0; k < 32000; k++) write_byte(8'($urandom));
      wait_drain();
      check("stream_pairs", 32'(pops - pops0), 32'd8000);
      drain_en = 1'b0;
      repeat (5) tick();
      check_idle("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
